hc595_rx: RTL and testbench
===========================

Name: hc595_rx

Overview:
Receiver for the 3-wire HC595 serial interface (SRCLK, DIO, RCLK) that the board's 595 driver produces. It synchronises the three pins into the clk domain and shifts DIO on each SRCLK rise. On each RCLK rise it commits a 16-bit frame to parallel seg/sel outputs. Used as an HC595 emulator for loopback checking of the driver and as a 3-wire slave input elsewhere in the design.

Parameters:
IDLE_TIMEOUT, 1024, clk cycles without any SRCLK/RCLK rise before a partial frame is discarded (must be >= 4)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SRCLK  in  1  serial shift clock, asynchronous to clk
DIO  in  1  serial data, MSB first (seg[7] first, sel[0] last)
RCLK  in  1  latch strobe, asynchronous to clk
seg  out  8  committed segment byte
sel  out  8  committed select byte
frame_valid  out  1  one-cycle pulse when seg/sel update
frame_err  out  1  one-cycle pulse on RCLK rise with bit count not 0 and not 16
timeout_err  out  1  one-cycle pulse when a partial frame is dropped by timeout
busy  out  1  high when state != IDLE

Behaviour:
- Reset: interface is clock clk, reset asynchronous active-high named reset. All outputs are 0, the shift register is 0, bit_cnt is 0, the timeout counter is 0, state is IDLE, and all synchroniser flops are 0.
- Synchronisation: SRCLK, DIO and RCLK each pass through a 2-flop synchroniser, then an edge register; rise = s2 & ~s3. DIO uses the same depth, so the data bit is aligned with its SRCLK rise.
- Input requirement: each SRCLK/RCLK level is held >= 2 clk cycles, and DIO is stable while SRCLK is high. The driver's default settings meet this.
- Latency: a pin transition first sampled at clk edge E0 is seen as a rise in the cycle after E1. Resulting register updates (shift, seg/sel, pulses) occur at E2.
- Shift rule: shreg <= {shreg[14:0], DIO_sync} on each SRCLK rise. At commit, seg = shreg[15:8] and sel = shreg[7:0].
- bit_cnt: 5 bits, saturates at 31.
- State IDLE (bit_cnt = 0):
  - SRCLK rise -> SHIFT, bit_cnt = 1.
  - RCLK rise -> ignored: no update, no error. This covers the driver's first latch after reset.
- State SHIFT (1..15 bits):
  - SRCLK rise -> bit_cnt+1; on reaching 16 -> FULL.
  - RCLK rise -> frame_err, seg/sel held, -> IDLE, bit_cnt = 0.
- State FULL (16 bits):
  - RCLK rise -> seg/sel <= shreg, frame_valid, -> IDLE.
  - SRCLK rise -> OVER, shift continues.
- State OVER (>16 bits):
  - SRCLK rise -> keep shifting.
  - RCLK rise -> frame_err, seg/sel held, -> IDLE.
- Simultaneous SRCLK and RCLK rise in one cycle:
  - The RCLK action is evaluated on the pre-shift shreg/bit_cnt (commit or error as above).
  - The new bit then starts the next frame: state SHIFT, bit_cnt = 1.
- Timeout:
  - The counter clears on any SRCLK/RCLK rise and otherwise increments while state != IDLE.
  - On reaching IDLE_TIMEOUT-1: timeout_err pulse, -> IDLE, bit_cnt = 0, seg/sel held.
  - The counter does not run in IDLE.
- Reset mid-frame: the partial frame is lost. seg/sel return to 0 and no pulse is issued.
- Pulses are never asserted in consecutive cycles from the same event. frame_valid and frame_err are mutually exclusive.

Decomposition:
- Package hc595_pkg holds:
  - FRAME_BITS = 16
  - state enum IDLE/SHIFT/FULL/OVER (2-bit encoding)
  - the bit-order constant (MSB first, seg before sel)
- One sub-module, hc595_sync_edge: 2-flop synchroniser plus rise detect, outputs level and rise. Instantiated for SRCLK, RCLK and DIO; DIO uses the level only.
- The top level holds the FSM, shift register, bit counter and timeout counter.

Test Plan:
- Loopback with the existing 595 driver (50 MHz/12.5 MHz defaults), seg=8'hA5, sel=8'h3C -> the first RCLK after reset is ignored; the next latch gives seg=A5, sel=3C, one frame_valid pulse, no frame_err.
- Direct drive of 10 SRCLK pulses then RCLK -> frame_err pulse, seg/sel unchanged from the previous frame, busy falls.
- 17 SRCLK pulses (bits 1..17) then RCLK -> state OVER reached, frame_err, seg/sel unchanged.
- 8 SRCLK pulses then idle for IDLE_TIMEOUT cycles -> timeout_err exactly once, busy=0. Then a clean 16-bit frame 0xFF00 -> seg=FF, sel=00.
- 16 bits 0x1234, then RCLK and SRCLK rising together with DIO=1 -> seg=12, sel=34. Then 15 more bits + RCLK commits the new 16-bit frame (first bit = 1).
- Assert reset after 12 bits -> all outputs 0 immediately (asynchronous), no pulses. A following 16-bit frame commits correctly.

Source files
------------

// File: rtl/hc595_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_pkg
//  Description : Shared constants, FSM state type and bit-order helper for
//                the HC595 3-wire receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package hc595_pkg;

    localparam int FRAME_BITS = 16;   // seg byte followed by sel byte
    localparam int BYTE_BITS  = 8;
    localparam int CNT_W      = 5;    // bit counter, saturates at 31

    // DIO carries seg[7] first and sel[0] last.
    localparam bit MSB_FIRST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Append one serial bit to the frame register in line with the bit order.
    function automatic logic [FRAME_BITS-1:0] shift_in(
        input logic [FRAME_BITS-1:0] sr,
        input logic                  d
    );
        if (MSB_FIRST)
            return {sr[FRAME_BITS-2:0], d};
        else
            return {d, sr[FRAME_BITS-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_sync_edge
//  Description : Two-flop synchroniser followed by an edge register.
//                level = synchronised pin, rise = one-cycle rising-edge flag.
//  Ports       : clk, reset (async, active-high), din (async pin),
//                level (synchronised level), rise (rising-edge pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/hc595_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_rx
//  Description : HC595 3-wire (SRCLK/DIO/RCLK) receiver. Shifts DIO on each
//                SRCLK rise and commits a 16-bit frame to seg/sel on RCLK.
//  Ports       : clk, reset (async, active-high)
//                SRCLK, DIO, RCLK  - asynchronous serial pins
//                seg, sel          - committed frame bytes
//                frame_valid       - pulse on successful commit
//                frame_err         - pulse on latch with 1..15 or >16 bits
//                timeout_err       - pulse when a partial frame is dropped
//                busy              - frame in progress (state != IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SRCLK,
    input  logic       DIO,
    input  logic       RCLK,
    output logic [7:0] seg,
    output logic [7:0] sel,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int               TMO_W    = $clog2(IDLE_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic w_sck_rise;
    logic w_sck_level_unused;
    logic w_rck_rise;
    logic w_rck_level_unused;
    logic w_dio;
    logic w_dio_rise_unused;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [TMO_W-1:0]      r_tmo;

    // DIO goes through the same depth as SRCLK so the sampled bit lines up
    // with the SRCLK rise that qualifies it.
    hc595_sync_edge u_sync_srclk (
        .clk   (clk),
        .reset (reset),
        .din   (SRCLK),
        .level (w_sck_level_unused),
        .rise  (w_sck_rise)
    );

    hc595_sync_edge u_sync_rclk (
        .clk   (clk),
        .reset (reset),
        .din   (RCLK),
        .level (w_rck_level_unused),
        .rise  (w_rck_rise)
    );

    hc595_sync_edge u_sync_dio (
        .clk   (clk),
        .reset (reset),
        .din   (DIO),
        .level (w_dio),
        .rise  (w_dio_rise_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_tmo       <= '0;
            seg         <= '0;
            sel         <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;

            if (w_rck_rise) begin
                // Latch is judged on the frame as it stood before any
                // coincident SRCLK bit; that bit then opens the next frame.
                case (r_state)
                    FULL: begin
                        seg         <= r_shreg[FRAME_BITS-1:BYTE_BITS];
                        sel         <= r_shreg[BYTE_BITS-1:0];
                        frame_valid <= 1'b1;
                    end
                    SHIFT, OVER: frame_err <= 1'b1;
                    default: ;  // latch in IDLE is ignored
                endcase
                r_tmo <= '0;
                if (w_sck_rise) begin
                    r_shreg   <= shift_in(r_shreg, w_dio);
                    r_bit_cnt <= CNT_W'(1);
                    r_state   <= SHIFT;
                end else begin
                    r_bit_cnt <= '0;
                    r_state   <= IDLE;
                end
            end else if (w_sck_rise) begin
                r_tmo     <= '0;
                r_shreg   <= shift_in(r_shreg, w_dio);
                r_bit_cnt <= (r_bit_cnt == CNT_MAX) ? CNT_MAX : r_bit_cnt + CNT_W'(1);
                case (r_state)
                    IDLE:    r_state <= SHIFT;
                    SHIFT:   r_state <= (r_bit_cnt == CNT_LAST) ? FULL : SHIFT;
                    default: r_state <= OVER;
                endcase
            end else if (r_state != IDLE) begin
                if (r_tmo == TMO_LAST) begin
                    timeout_err <= 1'b1;
                    r_state     <= IDLE;
                    r_bit_cnt   <= '0;
                    r_tmo       <= '0;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hc595_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc595_rx
//  Description : Self-checking bench for hc595_rx. A frame-level model
//                (queue of received bits) predicts each output pulse and
//                pushes it to a scoreboard; a monitor pops on every pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_rx;

    localparam int T = 32;  // IDLE_TIMEOUT used for the DUT under test

    logic       clk = 1'b0;
    logic       reset;
    logic       SRCLK;
    logic       DIO;
    logic       RCLK;
    logic [7:0] seg;
    logic [7:0] sel;
    logic       frame_valid;
    logic       frame_err;
    logic       timeout_err;
    logic       busy;

    hc595_rx #(.IDLE_TIMEOUT(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .SRCLK       (SRCLK),
        .DIO         (DIO),
        .RCLK        (RCLK),
        .seg         (seg),
        .sel         (sel),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // kind is one-hot {timeout_err, frame_err, frame_valid}
    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] seg;
        logic [7:0] sel;
    } exp_t;

    exp_t       exp_q[$];
    bit         model_bits[$];
    logic [7:0] m_seg;
    logic [7:0] m_sel;
    int         vectors;
    int         miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (frame_valid || frame_err || timeout_err)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse: got %b, expected no pulse",
                         {timeout_err, frame_err, frame_valid});
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {29'd0, timeout_err, frame_err, frame_valid}, {29'd0, e.kind});
                check("seg_at_pulse", {24'd0, seg}, {24'd0, e.seg});
                check("sel_at_pulse", {24'd0, sel}, {24'd0, e.sel});
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_latch();
        exp_t e;
        logic [15:0] w;
        if (model_bits.size() == 16) begin
            // first bit received is seg[7], last is sel[0]
            for (int i = 0; i < 16; i++) w[15-i] = model_bits[i];
            m_seg  = w[15:8];
            m_sel  = w[7:0];
            e.kind = 3'b001;
            e.seg  = m_seg;
            e.sel  = m_sel;
            exp_q.push_back(e);
        end else if (model_bits.size() > 0) begin
            e.kind = 3'b010;
            e.seg  = m_seg;
            e.sel  = m_sel;
            exp_q.push_back(e);
        end
        model_bits.delete();
    endtask

    task automatic model_timeout();
        exp_t e;
        if (model_bits.size() > 0) begin
            e.kind = 3'b100;
            e.seg  = m_seg;
            e.sel  = m_sel;
            exp_q.push_back(e);
        end
        model_bits.delete();
    endtask

    // ---------------- pin drivers ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit d);
        DIO = d;
        hold($urandom_range(4, 2));
        SRCLK = 1'b1;
        hold($urandom_range(4, 2));
        SRCLK = 1'b0;
        model_bits.push_back(d);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)));
    endtask

    task automatic send_latch();
        model_latch();
        hold($urandom_range(3, 2));
        RCLK = 1'b1;
        hold($urandom_range(4, 2));
        RCLK = 1'b0;
        hold(2);
    endtask

    // SRCLK and RCLK rise on the same clk edge.
    task automatic send_both(input bit d);
        DIO = d;
        hold($urandom_range(4, 2));
        model_latch();
        model_bits.push_back(d);
        SRCLK = 1'b1;
        RCLK  = 1'b1;
        hold($urandom_range(4, 2));
        SRCLK = 1'b0;
        RCLK  = 1'b0;
        hold(2);
    endtask

    task automatic idle_gap(input int n);
        if (n >= T + 8) model_timeout();
        hold(n);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_quiet();
        hold(4);
        drain();
        check("seg_held", {24'd0, seg}, {24'd0, m_seg});
        check("sel_held", {24'd0, sel}, {24'd0, m_sel});
        check("busy", {31'd0, busy}, {31'd0, (model_bits.size() > 0)});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        m_seg       = 8'h00;
        m_sel       = 8'h00;
        reset       = 1'b1;
        SRCLK       = 1'b0;
        DIO         = 1'b0;
        RCLK        = 1'b0;
        hold(3);
        reset = 1'b0;
        hold(1);
        check("reset_seg", {24'd0, seg}, 32'd0);
        check("reset_sel", {24'd0, sel}, 32'd0);
        check("reset_pulses", {29'd0, timeout_err, frame_err, frame_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // first latch after reset is ignored, then a good frame
        send_latch();
        check_quiet();
        send_word(16'hA53C);
        check_quiet();
        send_latch();
        check_quiet();
        check("loopback_seg", {24'd0, seg}, 32'hA5);
        check("loopback_sel", {24'd0, sel}, 32'h3C);

        // short frame
        send_rand(10);
        check_quiet();
        send_latch();
        check_quiet();

        // overlong frame
        send_rand(17);
        send_latch();
        check_quiet();

        // partial frame dropped by timeout, then a clean frame
        send_rand(8);
        idle_gap(T + 8);
        check_quiet();
        send_word(16'hFF00);
        send_latch();
        check_quiet();
        check("after_timeout_seg", {24'd0, seg}, 32'hFF);
        check("after_timeout_sel", {24'd0, sel}, 32'h00);

        // a pause shorter than the timeout keeps the frame alive
        send_rand(5);
        idle_gap(T / 2);
        send_rand(11);
        send_latch();
        check_quiet();

        // coincident latch + shift
        send_word(16'h1234);
        send_both(1'b1);
        check_quiet();
        check("coincident_seg", {24'd0, seg}, 32'h12);
        check("coincident_sel", {24'd0, sel}, 32'h34);
        send_rand(15);
        send_latch();
        check_quiet();

        // asynchronous reset mid-frame
        send_rand(12);
        hold(4);
        drain();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_seg = 8'h00;
        m_sel = 8'h00;
        model_bits.delete();
        check("async_reset_seg", {24'd0, seg}, 32'd0);
        check("async_reset_sel", {24'd0, sel}, 32'd0);
        check("async_reset_pulses", {29'd0, timeout_err, frame_err, frame_valid}, 32'd0);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        hold(3);
        reset = 1'b0;
        hold(2);
        send_word(16'hC3E7);
        send_latch();
        check_quiet();

        // randomized mix of frames
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(5, 0))
                0:       n = $urandom_range(20, 0);
                default: n = 16;
            endcase
            send_rand(n);
            if ($urandom_range(7, 0) == 0) idle_gap(T / 2);
            case ($urandom_range(9, 0))
                0:       idle_gap(T + 8);
                1:       send_both(1'($urandom_range(1, 0)));
                default: send_latch();
            endcase
            if ($urandom_range(3, 0) == 0) check_quiet();
        end
        send_latch();
        check_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
